fft8_twiddle_sequencer: RTL and testbench

- Streaming controller that applies stage-1 radix-2 DIF twiddles W8^e to 8-sample complex frames. It sits between the first butterfly stage and the second.
- It tracks the sample index within each frame and selects pass-through, −j rotation, or the shared 1/√2 twiddle multiplier, driving that multiplier's ctrl line.
- It applies the post-sign correction, registers the result behind a valid/ready handshake, and flags framing errors.

---
 rtl/fft_pkg.sv | 29 ++
 rtl/fft8_twiddle_sequencer_if.sv | 35 +++
 rtl/complex_multiplier_FFT.sv | 38 +++
 rtl/fft8_twiddle_sequencer.sv | 152 +++++++++++++++
 tb/tb_fft8_twiddle_sequencer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants and encodings for the 8-point FFT stage-1 twiddle path.
package fft_pkg;

   localparam int DATA_W    = 16;
   localparam int FRAME_LEN = 8;
   localparam int IDX_W     = 3;

   // Index of the final sample in a frame.
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   // 1/sqrt(2) in Q15 and the rounding half-LSB used by the constant multiplier.
   localparam logic signed [2*DATA_W:0] INV_SQRT2_Q15 = 33'sd23170;
   localparam logic signed [2*DATA_W:0] Q15_HALF      = 33'sd16384;

   // Twiddle applied to a sample.
   typedef enum logic [1:0] {
      TW_PASS = 2'd0,
      TW_W1   = 2'd1,
      TW_NJ   = 2'd2,
      TW_W3   = 2'd3
   } tw_sel_e;

   // Frame tracking state.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/fft8_twiddle_sequencer_if.sv
// Sample stream into and out of the twiddle sequencer.
//
// Handshake: a word moves across a link in every cycle where its valid and
// ready are both high at the rising clock edge. A producer that raised valid
// keeps valid and its payload stable until that transfer happens; ready may
// depend combinationally on the consumer's state but never on valid.
interface fft8_twiddle_sequencer_if;
   import fft_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_re;
   logic [DATA_W-1:0] in_im;
   logic              in_last;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_re;
   logic [DATA_W-1:0] out_im;
   logic              out_last;
   logic [IDX_W-1:0]  out_idx;

   // Environment side: feeds samples in and drains results.
   modport master (
      output in_valid, in_re, in_im, in_last, out_ready,
      input  in_ready, out_valid, out_re, out_im, out_last, out_idx
   );

   // Sequencer side.
   modport slave (
      input  in_valid, in_re, in_im, in_last, out_ready,
      output in_ready, out_valid, out_re, out_im, out_last, out_idx
   );

endinterface

// File: rtl/complex_multiplier_FFT.sv
// Shared 1/sqrt(2) twiddle multiplier, purely combinational.
// ctrl=0: r=(a+b)/sqrt2, i=(b-a)/sqrt2.  ctrl=1: r=(b-a)/sqrt2, i=(a+b)/sqrt2.
// Sums are formed at full width, scaled in Q15 with round-half-up and then
// wrapped to DATA_W bits.
module complex_multiplier_FFT
   import fft_pkg::*;
(
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic              i_ctrl,
   output logic [DATA_W-1:0] o_r,
   output logic [DATA_W-1:0] o_i
);

   localparam int EXT_W = 2 * DATA_W + 1;

   logic signed [EXT_W-1:0] w_sum;
   logic signed [EXT_W-1:0] w_diff;
   logic [DATA_W-1:0]       w_sum_q;
   logic [DATA_W-1:0]       w_diff_q;

   assign w_sum  = {{(EXT_W-DATA_W){i_a[DATA_W-1]}}, i_a} + {{(EXT_W-DATA_W){i_b[DATA_W-1]}}, i_b};
   assign w_diff = {{(EXT_W-DATA_W){i_b[DATA_W-1]}}, i_b} - {{(EXT_W-DATA_W){i_a[DATA_W-1]}}, i_a};

   assign w_sum_q  = DATA_W'((w_sum  * INV_SQRT2_Q15 + Q15_HALF) >>> 15);
   assign w_diff_q = DATA_W'((w_diff * INV_SQRT2_Q15 + Q15_HALF) >>> 15);

   // Route the scaled sum/difference to r/i according to ctrl.
   always_comb begin
      o_r = w_sum_q;
      o_i = w_diff_q;
      if (i_ctrl) begin
         o_r = w_diff_q;
         o_i = w_sum_q;
      end
   end

endmodule

// File: rtl/fft8_twiddle_sequencer.sv
// Stage-1 radix-2 DIF twiddle sequencer for 8-sample complex frames.
// Tracks the in-frame index, picks pass / -j / shared 1/sqrt2 multiplier,
// applies the sign fix-up and registers the result behind valid/ready.
module fft8_twiddle_sequencer #(
   parameter int DATA_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    bypass,
   fft8_twiddle_sequencer_if.slave bus,
   output logic                    frame_err,
   output fft_pkg::state_e         o_dbg_state
);
   import fft_pkg::*;

   if (DATA_W != fft_pkg::DATA_W || FRAME_LEN != 8) begin : g_bad_cfg
      $error("fft8_twiddle_sequencer supports only DATA_W=16 and FRAME_LEN=8");
   end

   state_e            r_state;
   state_e            w_state_nxt;
   logic [IDX_W-1:0]  r_n;
   logic [IDX_W-1:0]  w_n_nxt;
   logic              w_err_nxt;
   logic              r_frame_err;
   logic              w_accept;
   tw_sel_e           w_sel;
   logic              w_mul_ctrl;
   logic [DATA_W-1:0] w_x;
   logic [DATA_W-1:0] w_y;
   logic [DATA_W-1:0] w_mul_r;
   logic [DATA_W-1:0] w_mul_i;
   logic [DATA_W-1:0] w_res_re;
   logic [DATA_W-1:0] w_res_im;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_re;
   logic [DATA_W-1:0] r_out_im;
   logic [IDX_W-1:0]  r_out_idx;

   assign w_x      = bus.in_re;
   assign w_y      = bus.in_im;
   assign w_accept = bus.in_valid && bus.in_ready;

   // Index n chooses the twiddle; bypass forces pass-through per sample.
   always_comb begin
      w_sel = TW_PASS;
      if (!bypass) begin
         case (r_n)
            3'd5:    w_sel = TW_W1;
            3'd6:    w_sel = TW_NJ;
            3'd7:    w_sel = TW_W3;
            default: w_sel = TW_PASS;
         endcase
      end
   end

   // ctrl only matters for W8^3; held low whenever the multiplier is unused.
   assign w_mul_ctrl = (w_sel == TW_W3);

   complex_multiplier_FFT u_mult (
      .i_a    (w_x),
      .i_b    (w_y),
      .i_ctrl (w_mul_ctrl),
      .o_r    (w_mul_r),
      .o_i    (w_mul_i)
   );

   // Apply the selected rotation; negations wrap, so -(-32768) stays -32768.
   always_comb begin
      w_res_re = w_x;
      w_res_im = w_y;
      case (w_sel)
         TW_W1: begin
            w_res_re = w_mul_r;
            w_res_im = w_mul_i;
         end
         TW_NJ: begin
            w_res_re = w_y;
            w_res_im = -w_x;
         end
         TW_W3: begin
            w_res_re = w_mul_r;
            w_res_im = -w_mul_i;
         end
         default: begin
            w_res_re = w_x;
            w_res_im = w_y;
         end
      endcase
   end

   // Next index/state and framing error; both framing faults close the frame.
   always_comb begin
      w_state_nxt = r_state;
      w_n_nxt     = r_n;
      w_err_nxt   = 1'b0;
      if (w_accept) begin
         if (r_n == LAST_IDX) begin
            w_n_nxt     = '0;
            w_state_nxt = IDLE;
            w_err_nxt   = !bus.in_last;
         end else if (bus.in_last) begin
            w_n_nxt     = '0;
            w_state_nxt = IDLE;
            w_err_nxt   = 1'b1;
         end else begin
            w_n_nxt     = r_n + 3'd1;
            w_state_nxt = RUN;
         end
      end
   end

   // State, index counter and the one-cycle framing error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_n         <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_n         <= w_n_nxt;
         r_frame_err <= w_err_nxt;
      end
   end

   // Output register: load on accept (even while draining), clear valid on drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_re    <= '0;
         r_out_im    <= '0;
         r_out_idx   <= '0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_re    <= w_res_re;
         r_out_im    <= w_res_im;
         r_out_idx   <= r_n;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = !r_out_valid || bus.out_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_re    = r_out_re;
   assign bus.out_im    = r_out_im;
   assign bus.out_idx   = r_out_idx;
   assign bus.out_last  = (r_out_idx == LAST_IDX);
   assign frame_err     = r_frame_err;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_fft8_twiddle_sequencer.sv
// Self-checking bench for fft8_twiddle_sequencer. Inputs change on the falling
// edge; outputs are observed on the falling edge or 1 ns after it.
module tb_fft8_twiddle_sequencer;
   import fft_pkg::*;

   localparam real SQRT2 = 1.4142135623730951;

   logic   clk = 1'b0;
   logic   rst;
   logic   bypass;
   logic   frame_err;
   state_e dbg_state;

   fft8_twiddle_sequencer_if bus ();

   fft8_twiddle_sequencer #(.DATA_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .bypass      (bypass),
      .bus         (bus),
      .frame_err   (frame_err),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_n      = 0;     // reference in-frame index
   logic m_err    = 1'b0;  // reference frame_err for the coming cycle
   // {approx, re[15:0], im[15:0], idx[2:0], last}
   logic [36:0] exp_q[$];

   function automatic int rnd(input real v);
      return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
   endfunction

   function automatic logic [15:0] rand_s();
      int v;
      v = int'($urandom_range(32767, 0)) - 16384;
      return 16'(v);
   endfunction

   // Rotation by W8^e straight from the math; 1/sqrt2 terms tolerate 1 LSB.
   function automatic logic [36:0] model_out(input logic [15:0] x, input logic [15:0] y,
                                             input int n, input logic b);
      int xi, yi;
      real s, d;
      logic [15:0] re, im;
      logic tol;
      xi = int'($signed(x));
      yi = int'($signed(y));
      s = real'(xi + yi) / SQRT2;
      d = real'(yi - xi) / SQRT2;
      re = x;
      im = y;
      tol = 1'b0;
      if (!b) begin
         if (n == 5) begin
            re = 16'(rnd(s)); im = 16'(rnd(d)); tol = 1'b1;
         end else if (n == 6) begin
            re = y; im = 16'(-xi);
         end else if (n == 7) begin
            re = 16'(rnd(d)); im = 16'(-rnd(s)); tol = 1'b1;
         end
      end
      return {tol, re, im, 3'(n), (n == 7)};
   endfunction

   // Reference for an accepted sample: queue its output, advance the index.
   task automatic model_accept(input logic [15:0] x, input logic [15:0] y,
                               input logic l, input logic b);
      exp_q.push_back(model_out(x, y, m_n, b));
      if (m_n == 7) begin
         m_err = !l;
         m_n = 0;
      end else if (l) begin
         m_err = 1'b1;
         m_n = 0;
      end else begin
         m_err = 1'b0;
         m_n++;
      end
   endtask

   task automatic set_in(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic l, input logic b, input logic r);
      bus.in_valid  = v;
      bus.in_re     = x;
      bus.in_im     = y;
      bus.in_last   = l;
      bypass        = b;
      bus.out_ready = r;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      n_checks += 8;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      if (bus.out_re !== 16'h0) begin n_fail++; $display("FAIL reset_out_re: got %h want 0000", bus.out_re); end
      if (bus.out_im !== 16'h0) begin n_fail++; $display("FAIL reset_out_im: got %h want 0000", bus.out_im); end
      if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
      if (bus.out_idx !== 3'd0) begin n_fail++; $display("FAIL reset_out_idx: got %0d want 0", bus.out_idx); end
      if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
      rst = 1'b0;
      m_n = 0;
      exp_q.delete();
   endtask

   // Test-plan frame of (0x1000, 0) with fixed expected outputs, latency 1.
   task automatic test_frame_basic();
      logic [15:0] t_re[8];
      logic [15:0] t_im[8];
      t_re = '{16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h0B50, 16'h0000, 16'hF4B0};
      t_im = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hF4B0, 16'hF000, 16'hF4B0};
      for (int k = 0; k < 8; k++) begin
         set_in(1'b1, 16'h1000, 16'h0000, (k == 7), 1'b0, 1'b1);
         @(negedge clk);
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.out_re !== t_re[k] || bus.out_im !== t_im[k] ||
             bus.out_idx !== 3'(k) || bus.out_last !== (k == 7) || frame_err !== 1'b0)
         begin
            n_fail++;
            $display("FAIL basic_idx%0d: got v=%b re=%h im=%h idx=%0d last=%b err=%b, want v=1 re=%h im=%h idx=%0d last=%b err=0",
                     k, bus.out_valid, bus.out_re, bus.out_im, bus.out_idx, bus.out_last, frame_err,
                     t_re[k], t_im[k], k, (k == 7));
         end
      end
      set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got out_valid=%b want 0", bus.out_valid); end
   endtask

   // -j rotation at n=6, including the -(-32768) wrap.
   task automatic test_neg_j();
      logic [15:0] x, y, w_re, w_im;
      logic [36:0] e;
      int dre, dim, k;
      logic v;
      for (int c = 0; c <= 16; c++) begin
         v = (c < 16);
         k = c % 8;
         x = rand_s();
         y = rand_s();
         if (k == 6) begin
            x = (c < 8) ? 16'h1000 : 16'h8000;
            y = (c < 8) ? 16'h0200 : 16'h8000;
         end
         w_re = (c < 8) ? 16'h0200 : 16'h8000;
         w_im = (c < 8) ? 16'hF000 : 16'h8000;
         set_in(v, x, y, (k == 7), 1'b0, 1'b1);
         #1;
         if (bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL negj_extra: got re=%h im=%h idx=%0d, want no output", bus.out_re, bus.out_im, bus.out_idx);
            end else begin
               e = exp_q.pop_front();
               dre = int'($signed(bus.out_re)) - int'($signed(e[35:20]));
               dim = int'($signed(bus.out_im)) - int'($signed(e[19:4]));
               if ((e[36] ? (dre > 1 || dre < -1 || dim > 1 || dim < -1) : (dre != 0 || dim != 0)) ||
                   bus.out_idx !== e[3:1] || bus.out_last !== e[0]) begin
                  n_fail++;
                  $display("FAIL negj_out: got re=%h im=%h idx=%0d last=%b, want re=%h im=%h idx=%0d last=%b",
                           bus.out_re, bus.out_im, bus.out_idx, bus.out_last, e[35:20], e[19:4], e[3:1], e[0]);
               end
            end
         end
         m_err = 1'b0;
         if (v && bus.in_ready) model_accept(x, y, (k == 7), 1'b0);
         @(negedge clk);
         n_checks++;
         if (frame_err !== m_err) begin n_fail++; $display("FAIL negj_err: got %b want %b", frame_err, m_err); end
         if (v && k == 6) begin
            n_checks++;
            if (bus.out_re !== w_re || bus.out_im !== w_im) begin
               n_fail++;
               $display("FAIL negj_n6: got re=%h im=%h want re=%h im=%h", bus.out_re, bus.out_im, w_re, w_im);
            end
         end
      end
   endtask

   // out_ready low for three cycles with in_valid held high.
   task automatic test_stall();
      logic [15:0] xs[8], ys[8], hold_re, hold_im;
      logic [36:0] e;
      int dre, dim, k;
      logic v, r;
      k = 0;
      for (int i = 0; i < 8; i++) begin xs[i] = rand_s(); ys[i] = rand_s(); end
      hold_re = xs[0];
      hold_im = ys[0];
      for (int c = 0; c < 12; c++) begin
         v = (k < 8);
         r = (c >= 4);
         set_in(v, v ? xs[k] : 16'h0, v ? ys[k] : 16'h0, (k == 7), 1'b0, r);
         #1;
         if (c >= 1 && c <= 3) begin
            n_checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_re !== hold_re ||
                bus.out_im !== hold_im || bus.out_idx !== 3'd0) begin
               n_fail++;
               $display("FAIL stall_hold_c%0d: got rdy=%b v=%b re=%h im=%h idx=%0d, want rdy=0 v=1 re=%h im=%h idx=0",
                        c, bus.in_ready, bus.out_valid, bus.out_re, bus.out_im, bus.out_idx, hold_re, hold_im);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL stall_extra: got re=%h im=%h idx=%0d, want no output", bus.out_re, bus.out_im, bus.out_idx);
            end else begin
               e = exp_q.pop_front();
               dre = int'($signed(bus.out_re)) - int'($signed(e[35:20]));
               dim = int'($signed(bus.out_im)) - int'($signed(e[19:4]));
               if ((e[36] ? (dre > 1 || dre < -1 || dim > 1 || dim < -1) : (dre != 0 || dim != 0)) ||
                   bus.out_idx !== e[3:1] || bus.out_last !== e[0]) begin
                  n_fail++;
                  $display("FAIL stall_out: got re=%h im=%h idx=%0d last=%b, want re=%h im=%h idx=%0d last=%b",
                           bus.out_re, bus.out_im, bus.out_idx, bus.out_last, e[35:20], e[19:4], e[3:1], e[0]);
               end
            end
         end
         m_err = 1'b0;
         if (v && bus.in_ready) begin
            model_accept(xs[k], ys[k], (k == 7), 1'b0);
            k++;
         end
         @(negedge clk);
      end
      n_checks++;
      if (exp_q.size() != 0 || k != 8) begin
         n_fail++; $display("FAIL stall_count: got pending=%0d sent=%0d, want pending=0 sent=8", exp_q.size(), k);
      end
   endtask

   // in_last at n=3, then a frame of 8 without in_last, then a clean frame.
   task automatic test_framing();
      logic [15:0] x, y;
      logic [36:0] e;
      int dre, dim, pulses;
      logic v, l;
      pulses = 0;
      for (int c = 0; c <= 20; c++) begin
         v = (c < 20);
         l = (c == 3 || c == 19);
         x = rand_s();
         y = rand_s();
         set_in(v, x, y, l, 1'b0, 1'b1);
         #1;
         if (bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL framing_extra: got re=%h im=%h idx=%0d, want no output", bus.out_re, bus.out_im, bus.out_idx);
            end else begin
               e = exp_q.pop_front();
               dre = int'($signed(bus.out_re)) - int'($signed(e[35:20]));
               dim = int'($signed(bus.out_im)) - int'($signed(e[19:4]));
               if ((e[36] ? (dre > 1 || dre < -1 || dim > 1 || dim < -1) : (dre != 0 || dim != 0)) ||
                   bus.out_idx !== e[3:1] || bus.out_last !== e[0]) begin
                  n_fail++;
                  $display("FAIL framing_out: got re=%h im=%h idx=%0d last=%b, want re=%h im=%h idx=%0d last=%b",
                           bus.out_re, bus.out_im, bus.out_idx, bus.out_last, e[35:20], e[19:4], e[3:1], e[0]);
               end
            end
         end
         m_err = 1'b0;
         if (v && bus.in_ready) model_accept(x, y, l, 1'b0);
         @(negedge clk);
         if (frame_err === 1'b1) pulses++;
         n_checks++;
         if (frame_err !== m_err) begin n_fail++; $display("FAIL framing_err_c%0d: got %b want %b", c, frame_err, m_err); end
      end
      n_checks++;
      if (pulses != 2) begin n_fail++; $display("FAIL framing_pulses: got %0d want 2", pulses); end
   endtask

   // bypass=1 passes a whole frame untouched with indices 0..7.
   task automatic test_bypass();
      for (int k = 0; k < 8; k++) begin
         set_in(1'b1, 16'h1000, 16'h0000, (k == 7), 1'b1, 1'b1);
         @(negedge clk);
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.out_re !== 16'h1000 || bus.out_im !== 16'h0000 ||
             bus.out_idx !== 3'(k) || bus.out_last !== (k == 7)) begin
            n_fail++;
            $display("FAIL bypass_idx%0d: got v=%b re=%h im=%h idx=%0d last=%b, want v=1 re=1000 im=0000 idx=%0d last=%b",
                     k, bus.out_valid, bus.out_re, bus.out_im, bus.out_idx, bus.out_last, k, (k == 7));
         end
      end
      set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
   endtask

   // Random valid/ready/bypass/last traffic against the reference model.
   task automatic test_random_stream();
      logic [15:0] x, y;
      logic [36:0] e;
      int dre, dim;
      logic v, l, b, r, acc, m_valid;
      m_valid = 1'b0;
      for (int c = 0; c < 404; c++) begin
         v = (c < 400) && ($urandom_range(3, 0) != 0);
         r = (c >= 400) || ($urandom_range(9, 0) < 7);
         b = ($urandom_range(3, 0) == 0);
         l = (m_n == 7) ? ($urandom_range(9, 0) != 0) : ($urandom_range(19, 0) == 0);
         x = rand_s();
         y = rand_s();
         set_in(v, x, y, l, b, r);
         #1;
         n_checks++;
         if (bus.in_ready !== (!m_valid || r)) begin
            n_fail++; $display("FAIL rand_in_ready_c%0d: got %b want %b", c, bus.in_ready, (!m_valid || r));
         end
         if (bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL rand_extra: got re=%h im=%h idx=%0d, want no output", bus.out_re, bus.out_im, bus.out_idx);
            end else begin
               e = exp_q.pop_front();
               dre = int'($signed(bus.out_re)) - int'($signed(e[35:20]));
               dim = int'($signed(bus.out_im)) - int'($signed(e[19:4]));
               if ((e[36] ? (dre > 1 || dre < -1 || dim > 1 || dim < -1) : (dre != 0 || dim != 0)) ||
                   bus.out_idx !== e[3:1] || bus.out_last !== e[0]) begin
                  n_fail++;
                  $display("FAIL rand_out_c%0d: got re=%h im=%h idx=%0d last=%b, want re=%h im=%h idx=%0d last=%b",
                           c, bus.out_re, bus.out_im, bus.out_idx, bus.out_last, e[35:20], e[19:4], e[3:1], e[0]);
               end
            end
         end
         m_err = 1'b0;
         acc = v && bus.in_ready;
         if (acc) model_accept(x, y, l, b);
         m_valid = acc || (m_valid && !r);
         @(negedge clk);
         n_checks++;
         if (bus.out_valid !== m_valid || frame_err !== m_err) begin
            n_fail++;
            $display("FAIL rand_state_c%0d: got v=%b err=%b want v=%b err=%b", c, bus.out_valid, frame_err, m_valid, m_err);
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_pending: got %0d want 0", exp_q.size()); end
   endtask

   // Reset while holding the idx5 output: everything clears, next sample is idx0.
   task automatic test_reset_midframe();
      rst = 1'b1;
      set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      m_n = 0;
      for (int k = 0; k < 6; k++) begin
         set_in(1'b1, rand_s(), rand_s(), 1'b0, 1'b0, 1'b1);
         @(negedge clk);
      end
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd5) begin
         n_fail++; $display("FAIL rstmid_pre: got v=%b idx=%0d want v=1 idx=5", bus.out_valid, bus.out_idx);
      end
      rst = 1'b1;
      set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.out_re !== 16'h0 || bus.out_im !== 16'h0 ||
          bus.out_idx !== 3'd0 || bus.out_last !== 1'b0 || frame_err !== 1'b0 || dbg_state !== IDLE) begin
         n_fail++;
         $display("FAIL rstmid_clear: got v=%b re=%h im=%h idx=%0d last=%b err=%b st=%0d, want all 0",
                  bus.out_valid, bus.out_re, bus.out_im, bus.out_idx, bus.out_last, frame_err, dbg_state);
      end
      set_in(1'b1, 16'h1234, 16'h0567, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd0 || bus.out_re !== 16'h1234 || bus.out_im !== 16'h0567) begin
         n_fail++;
         $display("FAIL rstmid_first: got v=%b idx=%0d re=%h im=%h, want v=1 idx=0 re=1234 im=0567",
                  bus.out_valid, bus.out_idx, bus.out_re, bus.out_im);
      end
      set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      test_reset();
      test_frame_basic();
      test_neg_j();
      test_stall();
      test_framing();
      test_bypass();
      test_random_stream();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion within 1 ms, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
